// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: load-size encoding,
// the default hardwired-zero register and the occupancy-counter width helper.
package wb_pkg;

   typedef enum logic [1:0] {
      LS_BYTE = 2'd0,
      LS_HALF = 2'd1,
      LS_WORD = 2'd2,
      LS_FULL = 2'd3
   } load_size_e;

   localparam int unsigned ZERO_REG_DEFAULT = 31;

   // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
   function automatic int unsigned cnt_w(int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bundles the memory-side handshake, register-file write port and forwarding
// lookup of the writeback stage.
interface writeback_stage_if import wb_pkg::*; #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] in_reg;
   logic [DATA_W-1:0] in_result;
   logic [DATA_W-1:0] in_load_data;
   logic              in_mem_to_reg;
   logic              in_reg_write;
   load_size_e        in_load_size;
   logic              in_load_signed;

   logic              rf_grant;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   logic [REG_AW-1:0] fwd_qreg;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   logic [CNT_W-1:0]  count;

   modport slave (
      input  in_valid, in_reg, in_result, in_load_data, in_mem_to_reg, in_reg_write,
             in_load_size, in_load_signed, rf_grant, fwd_qreg,
      output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, count
   );

   modport master (
      output in_valid, in_reg, in_result, in_load_data, in_mem_to_reg, in_reg_write,
             in_load_size, in_load_signed, rf_grant, fwd_qreg,
      input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data, count
   );

endinterface

// File: rtl/wb_load_format.sv
// Selects ALU result or load data and sign/zero-extends sub-word loads.
// Purely combinational; extension only applies to loads.
module wb_load_format import wb_pkg::*; #(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0] result_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              mem_to_reg_i,
   input  load_size_e        size_i,
   input  logic              signed_i,
   output logic [DATA_W-1:0] data_o
);

   localparam logic [DATA_W-1:0] Ones = '1;

   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] ext_mask;
   logic              sign_bit;

   always_comb begin
      src      = mem_to_reg_i ? load_data_i : result_i;
      ext_mask = '0;
      sign_bit = 1'b0;
      // ext_mask marks the bits above the loaded field; a 32-bit shift on a
      // 32-bit datapath yields zero, so word and full coincide there.
      unique case (size_i)
         LS_BYTE: begin
            ext_mask = Ones << 8;
            sign_bit = src[7];
         end
         LS_HALF: begin
            ext_mask = Ones << 16;
            sign_bit = src[15];
         end
         LS_WORD: begin
            ext_mask = Ones << 32;
            sign_bit = src[31];
         end
         LS_FULL: begin
            ext_mask = '0;
            sign_bit = 1'b0;
         end
      endcase

      data_o = src;
      if (mem_to_reg_i) begin
         data_o = (src & ~ext_mask) | ({DATA_W{signed_i & sign_bit}} & ext_mask);
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: formats retiring results, buffers register writes in a
// small FIFO drained by the register-file grant, and forwards buffered data.
module writeback_stage import wb_pkg::*; #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
   input logic              clk,
   input logic              rst_n,
   writeback_stage_if.slave wb
);

   localparam int unsigned       PTR_W     = $clog2(DEPTH);
   localparam int unsigned       CNT_W     = cnt_w(DEPTH);
   localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;

   logic [REG_AW-1:0] reg_q  [DEPTH];
   logic [REG_AW-1:0] reg_d  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DATA_W-1:0] fmt_data;
   logic              accept;
   logic              push;
   logic              pop;
   logic              not_empty;
   ptr_t              head_idx;
   ptr_t              fwd_idx;

   wb_load_format #(
      .DATA_W (DATA_W)
   ) u_load_format (
      .result_i     (wb.in_result),
      .load_data_i  (wb.in_load_data),
      .mem_to_reg_i (wb.in_mem_to_reg),
      .size_i       (wb.in_load_size),
      .signed_i     (wb.in_load_signed),
      .data_o       (fmt_data)
   );

   assign not_empty   = (count_q != '0);
   assign wb.in_ready = (count_q != FULL_CNT);
   assign accept      = wb.in_valid && wb.in_ready;
   assign push        = accept && wb.in_reg_write && (wb.in_reg != ZERO_ADDR);
   assign pop         = not_empty && wb.rf_grant;

   // When empty, show the most recently retired slot so the write port holds.
   assign head_idx    = not_empty ? rd_ptr_q : rd_ptr_q - PTR_W'(1);
   assign wb.rf_we    = not_empty;
   assign wb.rf_waddr = reg_q[head_idx];
   assign wb.rf_wdata = data_q[head_idx];
   assign wb.count    = count_q;

   always_comb begin
      reg_d    = reg_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         reg_d[wr_ptr_q]  = wb.in_reg;
         data_d[wr_ptr_q] = fmt_data;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Walk oldest to youngest so later matches overwrite earlier ones.
   always_comb begin
      wb.fwd_hit  = 1'b0;
      wb.fwd_data = '0;
      fwd_idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (reg_q[fwd_idx] == wb.fwd_qreg) &&
             (wb.fwd_qreg != ZERO_ADDR)) begin
            wb.fwd_hit  = 1'b1;
            wb.fwd_data = data_q[fwd_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         reg_q    <= reg_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, formatting, backpressure, ordering,
// forwarding, filtering and asynchronous reset, with hand-computed expectations.
module tb_writeback_stage;
   import wb_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   writeback_stage_if #(.DATA_W(64), .REG_AW(5), .DEPTH(4)) bus ();

   writeback_stage #(
      .DATA_W   (64),
      .REG_AW   (5),
      .DEPTH    (4),
      .ZERO_REG (31)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] r, input logic [63:0] res, input logic [63:0] ld,
                        input logic m2r, input load_size_e sz, input logic sgn);
      bus.in_valid       = 1'b1;
      bus.in_reg         = r;
      bus.in_result      = res;
      bus.in_load_data   = ld;
      bus.in_mem_to_reg  = m2r;
      bus.in_reg_write   = 1'b1;
      bus.in_load_size   = sz;
      bus.in_load_signed = sgn;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.rf_grant = 1'b1;
      bus.fwd_qreg = 5'd3;
      drive(5'd3, 64'h1234, 64'h0, 1'b0, LS_FULL, 1'b0);
      #23;
      chk("reset_rf_we", bus.rf_we, 1'b0);
      chk("reset_count", bus.count, 3'd0);
      chk("reset_in_ready", bus.in_ready, 1'b1);
      chk("reset_waddr", bus.rf_waddr, 5'd0);
      chk("reset_wdata", bus.rf_wdata, 64'h0);
      chk("reset_fwd_hit", bus.fwd_hit, 1'b0);
      chk("reset_fwd_data", bus.fwd_data, 64'h0);
      bus.in_valid = 1'b0;
      #4 rst_n = 1'b1;
      tick();

      // First write: one-cycle latency, then drained by the grant.
      drive(5'd3, 64'h1234, 64'h0, 1'b0, LS_FULL, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("first_rf_we", bus.rf_we, 1'b1);
      chk("first_waddr", bus.rf_waddr, 5'd3);
      chk("first_wdata", bus.rf_wdata, 64'h1234);
      chk("first_count", bus.count, 3'd1);
      tick();
      chk("first_drained_we", bus.rf_we, 1'b0);
      chk("first_hold_wdata", bus.rf_wdata, 64'h1234);
      chk("first_hold_waddr", bus.rf_waddr, 5'd3);

      // Load formatting.
      drive(5'd9, 64'hDEAD, 64'h80F0, 1'b1, LS_BYTE, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      chk("ld_byte_signed", bus.rf_wdata, 64'hFFFF_FFFF_FFFF_FFF0);
      tick();
      drive(5'd9, 64'hDEAD, 64'h80F0, 1'b1, LS_HALF, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("ld_half_unsigned", bus.rf_wdata, 64'h80F0);
      tick();
      drive(5'd9, 64'hDEAD, 64'h8000_0000, 1'b1, LS_WORD, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      chk("ld_word_signed", bus.rf_wdata, 64'hFFFF_FFFF_8000_0000);
      tick();
      drive(5'd9, 64'hDEAD, 64'h8123_4567_89AB_CDEF, 1'b1, LS_FULL, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      chk("ld_full", bus.rf_wdata, 64'h8123_4567_89AB_CDEF);
      tick();
      drive(5'd9, 64'h0000_0000_0000_0080, 64'h55, 1'b0, LS_BYTE, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      chk("alu_no_extend", bus.rf_wdata, 64'h80);
      tick();

      // Backpressure: fill with grant low, then drain in order.
      bus.rf_grant = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(5'(i), 64'h100 + 64'(i), 64'h0, 1'b0, LS_FULL, 1'b0);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("fill_count", bus.count, 3'd4);
      chk("fill_in_ready", bus.in_ready, 1'b0);
      chk("fill_head", bus.rf_waddr, 5'd1);
      tick();
      chk("hold_head_addr", bus.rf_waddr, 5'd1);
      chk("hold_head_data", bus.rf_wdata, 64'h101);
      chk("hold_count", bus.count, 3'd4);
      bus.rf_grant = 1'b1;
      tick();
      chk("drain_head2", bus.rf_waddr, 5'd2);
      chk("drain_count3", bus.count, 3'd3);
      chk("drain_in_ready", bus.in_ready, 1'b1);
      drive(5'd5, 64'h105, 64'h0, 1'b0, LS_FULL, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("pushpop_count", bus.count, 3'd3);
      chk("drain_head3", bus.rf_waddr, 5'd3);
      tick();
      chk("drain_head4", bus.rf_waddr, 5'd4);
      chk("drain_data4", bus.rf_wdata, 64'h104);
      tick();
      chk("drain_head5", bus.rf_waddr, 5'd5);
      chk("drain_data5", bus.rf_wdata, 64'h105);
      tick();
      chk("drain_empty", bus.rf_we, 1'b0);

      // Forwarding: youngest match wins.
      bus.rf_grant = 1'b0;
      drive(5'd7, 64'hA, 64'h0, 1'b0, LS_FULL, 1'b0);
      tick();
      drive(5'd7, 64'hB, 64'h0, 1'b0, LS_FULL, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      bus.fwd_qreg = 5'd7;
      #1;
      chk("fwd_hit7", bus.fwd_hit, 1'b1);
      chk("fwd_data7", bus.fwd_data, 64'hB);
      bus.fwd_qreg = 5'd8;
      #1;
      chk("fwd_miss8", bus.fwd_hit, 1'b0);
      bus.fwd_qreg = 5'd31;
      #1;
      chk("fwd_zero_reg", bus.fwd_hit, 1'b0);
      bus.fwd_qreg = 5'd7;
      bus.rf_grant = 1'b1;
      #1;
      chk("fwd_popping_data", bus.fwd_data, 64'hB);
      tick();
      chk("fwd_one_left", bus.fwd_data, 64'hB);
      chk("fwd_one_left_hit", bus.fwd_hit, 1'b1);
      tick();
      chk("fwd_empty_hit", bus.fwd_hit, 1'b0);

      // Filtering: zero register and non-writing instructions are consumed only.
      drive(5'd31, 64'h77, 64'h0, 1'b0, LS_FULL, 1'b0);
      chk("filter_ready", bus.in_ready, 1'b1);
      tick();
      chk("filter_zero_count", bus.count, 3'd0);
      chk("filter_zero_we", bus.rf_we, 1'b0);
      drive(5'd5, 64'h88, 64'h0, 1'b0, LS_FULL, 1'b0);
      bus.in_reg_write = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      chk("filter_nowr_count", bus.count, 3'd0);
      chk("filter_nowr_we", bus.rf_we, 1'b0);

      // Asynchronous reset with three entries buffered.
      bus.rf_grant = 1'b0;
      for (int i = 10; i <= 12; i++) begin
         drive(5'(i), 64'h200 + 64'(i), 64'h0, 1'b0, LS_FULL, 1'b0);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("prereset_count", bus.count, 3'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rf_we", bus.rf_we, 1'b0);
      chk("async_count", bus.count, 3'd0);
      chk("async_wdata", bus.rf_wdata, 64'h0);
      #4 rst_n = 1'b1;
      bus.rf_grant = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_reset_we", bus.rf_we, 1'b0);
         chk("post_reset_count", bus.count, 3'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
